arrow_queue: RTL

Scrolling note field for the DDR game: consumes the 0–9 value from the random-number stage once per scroll tick, turns it into an arrow on one of four lanes (or none), and shifts arrows down a ROWS-deep grid toward the hit row. It scores debounced button presses against the hit row, counts misses, and ends the game at a miss limit. The grid feeds the VGA/LED renderer; the score and miss outputs feed the seven-segment display.

---
 rtl/arrow_queue_pkg.sv | 43 ++++
 rtl/arrow_queue_if.sv | 29 ++
 rtl/arrow_queue_decode.sv | 12 +
 rtl/arrow_queue.sv | 103 ++++++++++
 4 files changed

// File: rtl/arrow_queue_pkg.sv
// Shared DDR game definitions: lane indices, game state, counter width and
// the per-cycle popcount / saturating-add helpers.
package ddr_pkg;

  localparam int NUM_LANES = 4;

  localparam int LANE_L = 0;
  localparam int LANE_D = 1;
  localparam int LANE_U = 2;
  localparam int LANE_R = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // The carry out of the 9-bit sum marks overflow; clamp to the counter max.
  function automatic cnt_t sat_add(input cnt_t a, input logic [3:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {5'b0_0000, inc};
    return sum[CNT_W] ? cnt_t'(CNT_MAX) : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/arrow_queue_if.sv
// Game-side bundle of the arrow queue: control/stimulus inputs toward the
// queue and the grid/score status it drives back to the display side.
interface arrow_queue_if #(
  parameter int ROWS = 8
) ();
  import ddr_pkg::*;

  logic              tick;
  logic              start;
  logic [4:0]        random_arrow;
  logic [3:0]        btn;
  logic [4*ROWS-1:0] grid;
  cnt_t              score;
  cnt_t              miss_count;
  logic              hit;
  logic              miss;
  logic              playing;
  logic              game_over;

  modport master (
    output tick, start, random_arrow, btn,
    input  grid, score, miss_count, hit, miss, playing, game_over
  );

  modport slave (
    input  tick, start, random_arrow, btn,
    output grid, score, miss_count, hit, miss, playing, game_over
  );
endinterface

// File: rtl/arrow_queue_decode.sv
// arrow_decode: maps a 0-9 random value to a one-hot lane mask; values 0-3
// select a lane, anything else spawns no arrow.
module arrow_decode (
  input  logic [4:0] value,
  output logic [3:0] lane_mask
);
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lane_mask = '0;
    if (value < 5'd4) lane_mask[value[1:0]] = 1'b1;
  end
endmodule

// File: rtl/arrow_queue.sv
// arrow_queue: scrolling note field. Spawns arrows on tick, shifts them toward
// the hit row, scores presses against that row and ends the game at MAX_MISS.
module arrow_queue
  import ddr_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int MAX_MISS = 10
) (
  input logic           clk,
  input logic           rst,
  arrow_queue_if.slave  bus
);

  localparam cnt_t MAX_MISS_C = cnt_t'(MAX_MISS);

  state_e                state_q, state_d;
  logic [ROWS-1:0][3:0]  grid_q, grid_d;
  cnt_t                  score_q, score_d;
  cnt_t                  miss_cnt_q, miss_cnt_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;

  logic [3:0] spawn_mask;
  logic [3:0] hit_mask, bad_mask, expired;
  logic [2:0] hit_inc;
  logic [3:0] miss_inc;

  arrow_decode u_decode (
    .value     (bus.random_arrow),
    .lane_mask (spawn_mask)
  );

  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    hit_mask   = '0;
    bad_mask   = '0;
    expired    = '0;
    hit_inc    = '0;
    miss_inc   = '0;

    unique case (state_q)
      RUN: begin
        if (miss_cnt_q >= MAX_MISS_C) state_d = OVER;
        // Buttons resolve against the hit row before any shift this cycle.
        hit_mask             = bus.btn & grid_q[ROWS-1];
        bad_mask             = bus.btn & ~grid_q[ROWS-1];
        grid_d[ROWS-1]       = grid_q[ROWS-1] & ~bus.btn;
        if (bus.tick) begin
          expired = grid_q[ROWS-1] & ~bus.btn;
          for (int r = ROWS - 1; r > 0; r--) grid_d[r] = grid_q[r-1];
          grid_d[0] = spawn_mask;
        end
        hit_inc    = popcount4(hit_mask);
        miss_inc   = popcount8({bad_mask, expired});
        score_d    = sat_add(score_q, {1'b0, hit_inc});
        miss_cnt_d = sat_add(miss_cnt_q, miss_inc);
      end
      IDLE, OVER: begin
        if (bus.start) begin
          state_d    = RUN;
          grid_d     = '0;
          score_d    = '0;
          miss_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    hit_d  = (hit_inc != '0);
    miss_d = (miss_inc != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grid_q     <= '0;
      score_q    <= '0;
      miss_cnt_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grid_q     <= grid_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign bus.grid       = grid_q;
  assign bus.score      = score_q;
  assign bus.miss_count = miss_cnt_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.playing    = (state_q == RUN);
  assign bus.game_over  = (state_q == OVER);

endmodule
